// File: rtl/fht_result_reader.sv
// ---------------------------------------------------------------------------
// fht_result_reader
//
// Unload engine for the FHT result RAM. Once the transform has finished, it
// walks every row of the four RAM banks through the shared read address. It
// optionally presents the rows in bit-reversed order. It then serialises the
// four bank words of each row into one valid/ready sample stream. It is the
// read-side counterpart of the row-by-row, bank-by-bank loader.
//
// Per row the sequence is ISSUE (1 cycle), WAIT (RD_LAT cycles) and STREAM
// (4 beats). With iREADY held high this gives 4 beats every RD_LAT+5 cycles.
// There is deliberately no prefetch of the next row.
//
// Ports
//   iCLK       clock
//   iRESET     asynchronous reset, active low
//   iSTART     one-cycle unload request, ignored while busy
//   iABORT     synchronous abort back to IDLE, no oDONE
//   oADDR_RD   row address fanned out to all four bank read ports
//   iDATA_0..3 bank read data, valid RD_LAT cycles after the address
//   oDATA      stream sample (bank word passed through unmodified)
//   oVALID     oDATA valid
//   iREADY     sink accepts the beat when oVALID & iREADY
//   oINDEX     linear sample index {row counter, bank}
//   oLAST      marks the final beat of the unload
//   oBUSY      unload in progress
//   oDONE      one-cycle pulse after the final beat is accepted
// ---------------------------------------------------------------------------
module fht_result_reader #(
   parameter int D_BIT   = 17,
   parameter int A_BIT   = 8,
   parameter int RD_LAT  = 2,
   parameter int BIT_REV = 1
) (
   input  logic               iCLK,
   input  logic               iRESET,
   input  logic               iSTART,
   input  logic               iABORT,
   output logic [A_BIT-1:0]   oADDR_RD,
   input  logic [D_BIT-1:0]   iDATA_0,
   input  logic [D_BIT-1:0]   iDATA_1,
   input  logic [D_BIT-1:0]   iDATA_2,
   input  logic [D_BIT-1:0]   iDATA_3,
   output logic [D_BIT-1:0]   oDATA,
   output logic               oVALID,
   input  logic               iREADY,
   output logic [A_BIT+1:0]   oINDEX,
   output logic               oLAST,
   output logic               oBUSY,
   output logic               oDONE
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ISSUE  = 2'd1,
      ST_WAIT   = 2'd2,
      ST_STREAM = 2'd3
   } state_t;

   localparam logic [A_BIT-1:0] ROW_MAX   = {A_BIT{1'b1}};
   // The wait counter starts at 0 in the first WAIT cycle. The data for the
   // address driven during ISSUE is therefore on the bus when it reaches
   // RD_LAT-1.
   localparam logic [2:0]       WAIT_LAST = 3'(RD_LAT - 1);

   // Mirror the row counter bits.
   function automatic logic [A_BIT-1:0] bit_rev(input logic [A_BIT-1:0] r);
      logic [A_BIT-1:0] v;
      v = '0;
      for (int i = 0; i < A_BIT; i++) begin
         v[A_BIT-1-i] = r[i];
      end
      return v;
   endfunction

   // Map a row counter value to the RAM row address.
   function automatic logic [A_BIT-1:0] row_addr(input logic [A_BIT-1:0] r);
      return (BIT_REV != 0) ? bit_rev(r) : r;
   endfunction

   state_t             state_r;
   logic [A_BIT-1:0]   row_r;
   logic [1:0]         beat_r;
   logic [2:0]         wait_r;
   logic [D_BIT-1:0]   hold_r [4];
   logic [A_BIT-1:0]   addr_r;
   logic [D_BIT-1:0]   data_r;
   logic               valid_r;
   logic [A_BIT+1:0]   index_r;
   logic               last_r;
   logic               busy_r;
   logic               done_r;

   logic               handshake_s;
   logic               row_last_s;
   logic [1:0]         beat_nxt_s;
   logic [A_BIT-1:0]   row_nxt_s;

   assign handshake_s = valid_r & iREADY;
   assign row_last_s  = (row_r == ROW_MAX);
   assign beat_nxt_s  = beat_r + 2'd1;
   assign row_nxt_s   = row_r + {{(A_BIT-1){1'b0}}, 1'b1};

   // Unload sequencer: this block owns all state and every registered output.
   always_ff @(posedge iCLK or negedge iRESET) begin
      if (!iRESET) begin
         state_r <= ST_IDLE;
         row_r   <= '0;
         beat_r  <= 2'd0;
         wait_r  <= 3'd0;
         for (int k = 0; k < 4; k++) begin
            hold_r[k] <= '0;
         end
         addr_r  <= '0;
         data_r  <= '0;
         valid_r <= 1'b0;
         index_r <= '0;
         last_r  <= 1'b0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else if (iABORT) begin
         // Abort acts as the synchronous soft reset of the sequencer. It
         // takes priority over iSTART. The address and sample registers keep
         // their last values.
         state_r <= ST_IDLE;
         row_r   <= '0;
         beat_r  <= 2'd0;
         wait_r  <= 3'd0;
         valid_r <= 1'b0;
         last_r  <= 1'b0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (iSTART) begin
                  // The address is registered on entry, so it is already on
                  // the bus during the ISSUE cycle.
                  state_r <= ST_ISSUE;
                  row_r   <= '0;
                  addr_r  <= row_addr('0);
                  busy_r  <= 1'b1;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_ISSUE: begin
               state_r <= ST_WAIT;
               wait_r  <= 3'd0;
            end
            ST_WAIT: begin
               if (wait_r == WAIT_LAST) begin
                  hold_r[0] <= iDATA_0;
                  hold_r[1] <= iDATA_1;
                  hold_r[2] <= iDATA_2;
                  hold_r[3] <= iDATA_3;
                  data_r    <= iDATA_0;
                  index_r   <= {row_r, 2'd0};
                  last_r    <= 1'b0;
                  valid_r   <= 1'b1;
                  beat_r    <= 2'd0;
                  state_r   <= ST_STREAM;
               end else begin
                  wait_r <= wait_r + 3'd1;
               end
            end
            ST_STREAM: begin
               if (!handshake_s) begin
                  // Stalled: the presented beat stays frozen.
                  state_r <= ST_STREAM;
               end else if (beat_r != 2'd3) begin
                  beat_r  <= beat_nxt_s;
                  data_r  <= hold_r[beat_nxt_s];
                  index_r <= {row_r, beat_nxt_s};
                  last_r  <= row_last_s && (beat_nxt_s == 2'd3);
               end else if (!row_last_s) begin
                  row_r   <= row_nxt_s;
                  addr_r  <= row_addr(row_nxt_s);
                  valid_r <= 1'b0;
                  last_r  <= 1'b0;
                  state_r <= ST_ISSUE;
               end else begin
                  row_r   <= '0;
                  beat_r  <= 2'd0;
                  valid_r <= 1'b0;
                  last_r  <= 1'b0;
                  busy_r  <= 1'b0;
                  done_r  <= 1'b1;
                  state_r <= ST_IDLE;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               valid_r <= 1'b0;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   assign oADDR_RD = addr_r;
   assign oDATA    = data_r;
   assign oVALID   = valid_r;
   assign oINDEX   = index_r;
   assign oLAST    = last_r;
   assign oBUSY    = busy_r;
   assign oDONE    = done_r;

endmodule

// File: tb/tb_fht_result_reader.sv
// ---------------------------------------------------------------------------
// Testbench for fht_result_reader. It runs two instances side by side, one
// with BIT_REV=0 and one with BIT_REV=1, and both share the control inputs.
// Each instance has its own RAM model with RD_LAT read latency. Expected
// samples are derived directly from the bank contents and the row-order rule.
// ---------------------------------------------------------------------------
module tb_fht_result_reader;

   localparam int D_BIT  = 17;
   localparam int A_BIT  = 3;
   localparam int RD_LAT = 2;
   localparam int NROW   = 8;
   localparam int NBEAT  = 4 * NROW;

   logic clk = 1'b0;
   logic rst_n;
   logic start;
   logic abort;
   logic ready;

   logic [A_BIT-1:0] addr_w  [2];
   logic [D_BIT-1:0] data_w  [2];
   logic             valid_w [2];
   logic [A_BIT+1:0] index_w [2];
   logic             last_w  [2];
   logic             busy_w  [2];
   logic             done_w  [2];

   logic [D_BIT-1:0] mem  [4][NROW];
   logic [A_BIT-1:0] pipe [2][RD_LAT];
   logic [D_BIT-1:0] rdat [2][4];

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   // RAM model: the address is delayed by RD_LAT clock edges and then read.
   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         pipe[i][0] <= addr_w[i];
         for (int j = 1; j < RD_LAT; j++) begin
            pipe[i][j] <= pipe[i][j-1];
         end
      end
   end

   always_comb begin
      for (int i = 0; i < 2; i++) begin
         for (int k = 0; k < 4; k++) begin
            rdat[i][k] = mem[k][pipe[i][RD_LAT-1]];
         end
      end
   end

   for (genvar g = 0; g < 2; g++) begin : g_dut
      fht_result_reader #(
         .D_BIT(D_BIT), .A_BIT(A_BIT), .RD_LAT(RD_LAT), .BIT_REV(g)
      ) u_dut (
         .iCLK(clk), .iRESET(rst_n), .iSTART(start), .iABORT(abort),
         .oADDR_RD(addr_w[g]),
         .iDATA_0(rdat[g][0]), .iDATA_1(rdat[g][1]),
         .iDATA_2(rdat[g][2]), .iDATA_3(rdat[g][3]),
         .oDATA(data_w[g]), .oVALID(valid_w[g]), .iREADY(ready),
         .oINDEX(index_w[g]), .oLAST(last_w[g]),
         .oBUSY(busy_w[g]), .oDONE(done_w[g])
      );
   end

   function automatic logic [A_BIT-1:0] rev3(input logic [A_BIT-1:0] r);
      logic [A_BIT-1:0] v;
      v = '0;
      for (int i = 0; i < A_BIT; i++) v[A_BIT-1-i] = r[i];
      return v;
   endfunction

   // RAM row that instance `inst` presents for row-group number `r`.
   function automatic logic [A_BIT-1:0] exp_row(input int inst, input int r);
      logic [A_BIT-1:0] rr;
      rr = A_BIT'(r);
      return (inst == 1) ? rev3(rr) : rr;
   endfunction

   // Sample n of the stream: row group n/4, bank n%4.
   function automatic logic [D_BIT-1:0] exp_sample(input int inst, input int n);
      return mem[n % 4][exp_row(inst, n / 4)];
   endfunction

   task automatic preload_plan();
      for (int k = 0; k < 4; k++)
         for (int r = 0; r < NROW; r++)
            mem[k][r] = D_BIT'(100 * r + k);
   endtask

   task automatic check_idle_zero(input string tag);
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (addr_w[i] !== '0 || data_w[i] !== '0 || valid_w[i] !== 1'b0 ||
             index_w[i] !== '0 || last_w[i] !== 1'b0 || busy_w[i] !== 1'b0 ||
             done_w[i] !== 1'b0) begin
            errors++;
            $display("FAIL %s[%0d]: addr=%0d data=%0d valid=%b index=%0d last=%b busy=%b done=%b, want all 0",
                     tag, i, addr_w[i], data_w[i], valid_w[i], index_w[i], last_w[i], busy_w[i], done_w[i]);
         end
      end
   endtask

   // Drive one unload and check every beat against the reference.
   // rmode: 0 = ready held high, 1 = ready pattern 1,0,0,1, 2 = random.
   // restart_beat: pulse iSTART while that beat is presented (-1 = never).
   // stop_beat: abort, or reset if by_reset, at that beat (-1 = never).
   task automatic unload(input int rmode, input int restart_beat, input int stop_beat,
                         input bit by_reset, output int got);
      int  n, cyc, pat;
      int  hs_cyc [NBEAT];
      bit  stalled, restarted, stopped, hs;
      logic exp_last;
      n = 0; cyc = 0; pat = 0; stalled = 1'b0; restarted = 1'b0; stopped = 1'b0;
      for (int j = 0; j < NBEAT; j++) hs_cyc[j] = 0;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (busy_w[i] !== 1'b1) begin
            errors++;
            $display("FAIL busy_on[%0d]: got %b want 1", i, busy_w[i]);
         end
      end
      while (n < NBEAT && cyc < 1000 && !stopped) begin
         exp_last = (n == NBEAT - 1);
         for (int i = 0; i < 2; i++) begin
            checks++;
            if (done_w[i] !== 1'b0) begin
               errors++;
               $display("FAIL early_done[%0d]: done=%b at beat %0d, want 0", i, done_w[i], n);
            end
            if (stalled) begin
               checks++;
               if (valid_w[i] !== 1'b1) begin
                  errors++;
                  $display("FAIL valid_drop[%0d]: valid=%b while stalled at beat %0d, want 1", i, valid_w[i], n);
               end
            end
            if (valid_w[i] === 1'b1) begin
               checks++;
               if (data_w[i] !== exp_sample(i, n) || index_w[i] !== (A_BIT+2)'(n) || last_w[i] !== exp_last) begin
                  errors++;
                  $display("FAIL beat[%0d]: n=%0d data=%0d index=%0d last=%b, want data=%0d index=%0d last=%b",
                           i, n, data_w[i], index_w[i], last_w[i], exp_sample(i, n), n, exp_last);
               end
            end
         end
         case (rmode)
            0:       ready = 1'b1;
            1:       ready = ((pat % 4) == 0) || ((pat % 4) == 3);
            default: ready = 1'($urandom_range(0, 1));
         endcase
         pat++;
         if (!restarted && valid_w[0] === 1'b1 && n == restart_beat) begin
            start = 1'b1;
            restarted = 1'b1;
         end
         hs = 1'b0;
         if (valid_w[0] === 1'b1 && n == stop_beat) begin
            ready = 1'b0;
            stopped = 1'b1;
            if (by_reset) begin
               #2 rst_n = 1'b0;
               #1 check_idle_zero("async_reset");
            end else begin
               abort = 1'b1;
            end
         end else if (valid_w[0] === 1'b1 && ready === 1'b1) begin
            hs = 1'b1;
            if (n % 4 == 0) begin
               for (int i = 0; i < 2; i++) begin
                  checks++;
                  if (addr_w[i] !== exp_row(i, n / 4)) begin
                     errors++;
                     $display("FAIL row_addr[%0d]: group %0d addr=%0d want %0d", i, n / 4, addr_w[i], exp_row(i, n / 4));
                  end
               end
            end
            hs_cyc[n] = cyc;
            n++;
         end
         stalled = (valid_w[0] === 1'b1) && !hs && !stopped;
         @(negedge clk);
         start = 1'b0;
         cyc++;
      end
      got = n;
      if (stopped && !by_reset) begin
         abort = 1'b0;
         for (int i = 0; i < 2; i++) begin
            checks++;
            if (valid_w[i] !== 1'b0 || busy_w[i] !== 1'b0 || done_w[i] !== 1'b0) begin
               errors++;
               $display("FAIL abort[%0d]: valid=%b busy=%b done=%b, want 0 0 0", i, valid_w[i], busy_w[i], done_w[i]);
            end
         end
      end else if (!stopped) begin
         checks++;
         if (n != NBEAT) begin
            errors++;
            $display("FAIL timeout: %0d beats received, want %0d", n, NBEAT);
         end else begin
            for (int i = 0; i < 2; i++) begin
               checks++;
               if (done_w[i] !== 1'b1 || busy_w[i] !== 1'b0 || valid_w[i] !== 1'b0) begin
                  errors++;
                  $display("FAIL done_pulse[%0d]: done=%b busy=%b valid=%b, want 1 0 0", i, done_w[i], busy_w[i], valid_w[i]);
               end
            end
            if (rmode == 0) begin
               checks++;
               if (hs_cyc[0] != RD_LAT + 1) begin
                  errors++;
                  $display("FAIL first_latency: first beat at cycle %0d want %0d", hs_cyc[0], RD_LAT + 1);
               end
               for (int r = 1; r < NROW; r++) begin
                  checks++;
                  if (hs_cyc[4*r] - hs_cyc[4*(r-1)] != RD_LAT + 5) begin
                     errors++;
                     $display("FAIL group_span: row %0d span %0d want %0d", r, hs_cyc[4*r] - hs_cyc[4*(r-1)], RD_LAT + 5);
                  end
               end
            end
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
               checks++;
               if (done_w[i] !== 1'b0) begin
                  errors++;
                  $display("FAIL done_width[%0d]: done=%b one cycle later, want 0", i, done_w[i]);
               end
            end
         end
      end
   endtask

   task automatic expect_idle_for(input int ncyc, input string tag);
      for (int c = 0; c < ncyc; c++) begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            checks++;
            if (busy_w[i] !== 1'b0 || valid_w[i] !== 1'b0) begin
               errors++;
               $display("FAIL %s[%0d]: busy=%b valid=%b, want 0 0", tag, i, busy_w[i], valid_w[i]);
            end
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; ready = 1'b0;
      repeat (2) @(negedge clk);
      check_idle_zero("reset");
      rst_n = 1'b1;
      expect_idle_for(3, "post_reset_idle");
   endtask

   task automatic test_stream();
      int got;
      preload_plan();
      unload(0, -1, -1, 1'b0, got);
   endtask

   task automatic test_backpressure();
      int got;
      unload(1, -1, -1, 1'b0, got);
   endtask

   task automatic test_restart_ignored();
      int got;
      unload(0, 10, -1, 1'b0, got);
   endtask

   task automatic test_abort();
      int got;
      unload(0, -1, 13, 1'b0, got);
      expect_idle_for(2, "after_abort");
      unload(2, -1, -1, 1'b0, got);
   endtask

   task automatic test_async_reset();
      int got;
      unload(1, -1, 20, 1'b1, got);
      @(negedge clk);
      check_idle_zero("reset_held");
      rst_n = 1'b1;
      expect_idle_for(5, "reset_release_idle");
      unload(0, -1, -1, 1'b0, got);
   endtask

   task automatic test_start_abort_same();
      @(negedge clk);
      start = 1'b1; abort = 1'b1;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      expect_idle_for(4, "start_abort_idle");
   endtask

   task automatic test_random_data();
      int got;
      for (int k = 0; k < 4; k++)
         for (int r = 0; r < NROW; r++)
            mem[k][r] = D_BIT'($urandom);
      unload(2, -1, -1, 1'b0, got);
      unload(1, -1, -1, 1'b0, got);
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_restart_ignored();
      test_abort();
      test_async_reset();
      test_start_abort_same();
      test_random_data();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fht_result_reader.md
Name: fht_result_reader

Overview:
- Unload engine for the FHT result RAM.
- After the transform completes, it walks all BANK_SIZE rows of the four RAM banks through the fht_top read ports (iADDR_RD_0..3 / oDATA_0..3).
- Optionally un-does the bit-reversed row order, and serialises the four bank words of each row into a single valid/ready sample stream.
- It is the read-side counterpart of the row-by-row, bank-by-bank loader that feeds iWE/iDATA/iADDR_WR.

Parameters:
- D_BIT, 17, width of one RAM word (signed, includes bit expansion).
- A_BIT, 8, row address width; BANK_SIZE = 2**A_BIT.
- RD_LAT, 2, RAM read latency in cycles from address to valid oDATA_k (1..4).
- BIT_REV, 1, 1: row address presented = bit-reverse(row counter); 0: row address = row counter.

Ports:
- iCLK  in  1  clock.
- iRESET  in  1  asynchronous reset, active-low.
- iSTART  in  1  single-cycle request to begin an unload; ignored while oBUSY=1.
- iABORT  in  1  synchronous abort; returns to IDLE next cycle, no oDONE.
- oADDR_RD  out  A_BIT  row address, fanned out to all four iADDR_RD_k.
- iDATA_0..iDATA_3  in  D_BIT each  RAM bank read data (from oDATA_0..3).
- oDATA  out  D_BIT  stream sample.
- oVALID  out  1  oDATA valid.
- iREADY  in  1  sink accepts the beat when oVALID&iREADY.
- oINDEX  out  A_BIT+2  linear sample index = {row counter, bank}.
- oLAST  out  1  high with the final beat (index 4*BANK_SIZE-1).
- oBUSY  out  1  high from the cycle after an accepted iSTART until DONE.
- oDONE  out  1  one-cycle pulse after the last beat is accepted.

Behaviour:
- Reset (iRESET=0, async): state IDLE; row counter, beat counter, wait counter = 0; oADDR_RD=0; oDATA=0; oVALID=0; oINDEX=0; oLAST=0; oBUSY=0; oDONE=0. Reset mid-unload aborts the unload immediately; nothing is retained.
- States: IDLE, ISSUE, WAIT, STREAM.
  - IDLE: on iSTART go to ISSUE; row counter := 0; oBUSY := 1.
  - ISSUE (1 cycle): drive oADDR_RD = BIT_REV ? rev(row) : row; go to WAIT; wait counter := 0.
  - WAIT: hold oADDR_RD. After RD_LAT cycles counted from the ISSUE cycle, capture iDATA_0..3 into a 4-word holding register. Then go to STREAM with beat counter = 0.
  - STREAM: oVALID=1; oDATA = hold[beat]; oINDEX = {row, beat}; oLAST = (row==BANK_SIZE-1 && beat==3).
    - On handshake with beat<3: beat++.
    - On handshake with beat==3 and row<BANK_SIZE-1: row++, go to ISSUE.
    - On handshake with beat==3 and row==BANK_SIZE-1: go to IDLE, pulse oDONE, oBUSY := 0, oVALID := 0.
- Handshake rules:
  - While oVALID=1 and iREADY=0, oDATA, oINDEX and oLAST are held stable.
  - oVALID never drops without a handshake, except on iABORT or reset.
- oADDR_RD holds its last value outside ISSUE/WAIT.
- Throughput: 4 beats per (RD_LAT+5) cycles with iREADY tied high. No prefetch.
- iSTART while busy is ignored. iSTART and iABORT in the same IDLE cycle: abort wins, stay IDLE.
- iABORT in any state: next cycle IDLE, oVALID=0, oBUSY=0, counters=0, no oDONE.
- Bit reverse: rev(r)[A_BIT-1-i] = r[i] for all i.
- Row counter wraps only via return to IDLE; it never increments past BANK_SIZE-1.
- Data is passed through unmodified; no sign or width change.

Test Plan:
- A_BIT=3, RD_LAT=2, BIT_REV=0. Preload bank k row r with 100*r+k. iSTART, iREADY=1 → 32 beats 0,1,2,3,100,...,703 with oINDEX 0..31. oLAST on beat 31. oDONE one cycle after the last handshake; each row group spans 7 cycles.
- Same preload, BIT_REV=1 → oADDR_RD sequence 0,4,2,6,1,5,3,7. First beats of the second group are 400..403; oINDEX still counts 0..31.
- Backpressure: iREADY toggles 1,0,0,1 repeatedly → every beat is delivered exactly once in order, oDATA stable while stalled, 32 handshakes total.
- iSTART pulsed again at beat 10 → ignored; sequence unchanged; exactly one oDONE.
- iABORT at beat 13 → next cycle oVALID=0, oBUSY=0, no oDONE. A subsequent iSTART restarts from oINDEX 0.
- iRESET low at beat 20 (async, mid-clock) → all outputs 0 immediately. After release the block stays IDLE until iSTART.
